// File: rtl/mult_div_if.sv
// mult_div_if: start/operand/result signals between control and the multiply/divide unit
interface mult_div_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HIout;
  logic [31:0] LOout;
  logic        busy;
  logic        done;
  logic        div_zero;
  modport master (output start_mult, start_div, A, B, input HIout, LOout, busy, done, div_zero);
  modport slave (input start_mult, start_div, A, B, output HIout, LOout, busy, done, div_zero);
endinterface

// File: rtl/mult_div.sv
// mult_div: iterative signed 32x32 Booth multiply and restoring divide producing HI/LO
module mult_div (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave io
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_e;
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] booth_q, booth_d;
  logic [31:0] mcand_q, mcand_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic        sa_q, sa_d, sb_q, sb_d, div_q, div_d, done_q, done_d, dz_q, dz_d;
  logic [32:0] sum, shl, trial;
  logic [31:0] a_mag, b_mag;
  assign io.HIout    = hi_q;
  assign io.LOout    = lo_q;
  assign io.busy     = state_q != IDLE;
  assign io.done     = done_q;
  assign io.div_zero = dz_q;
  // 33-bit Booth sum keeps the true sign so a -2^31 multiplicand cannot overflow the shift-in bit
  always_comb begin
    a_mag = io.A[31] ? -io.A : io.A;
    b_mag = io.B[31] ? -io.B : io.B;
    sum   = booth_q[1:0] == 2'b01 ? {booth_q[64], booth_q[64:33]} + {mcand_q[31], mcand_q} :
            booth_q[1:0] == 2'b10 ? {booth_q[64], booth_q[64:33]} - {mcand_q[31], mcand_q} :
                                    {booth_q[64], booth_q[64:33]};
    shl   = {rem_q, quo_q[31]};
    trial = shl - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    booth_d = booth_q;
    mcand_d = mcand_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start_mult) begin
          state_d = MULT;
          booth_d = {32'b0, io.B, 1'b0};
          mcand_d = io.A;
          div_d   = 1'b0;
        end else if (io.start_div && io.B == 32'b0) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else if (io.start_div) begin
          state_d = DIV;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = 32'b0;
          sa_d    = io.A[31];
          sb_d    = io.B[31];
          div_d   = 1'b1;
        end
      end
      MULT: begin
        booth_d = {sum, booth_q[32:1]};
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FINISH : MULT;
      end
      DIV: begin
        rem_d   = trial[32] ? shl[31:0] : trial[31:0];
        quo_d   = {quo_q[30:0], ~trial[32]};
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FINISH : DIV;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = div_q ? (sa_q ? -rem_q : rem_q) : booth_q[64:33];
        lo_d    = div_q ? ((sa_q ^ sb_q) ? -quo_q : quo_q) : booth_q[32:1];
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      booth_q <= '0;
      mcand_q <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      booth_q <= booth_d;
      mcand_q <= mcand_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
endmodule
